psum_accumulator: RTL and testbench

- Downstream consumer of the signed multiplier product (I_WIDTH+F_WIDTH bits) in the PE datapath.
- Accumulates a run-time-programmable number of consecutive products into one signed partial sum.
- Presents each finished sum on a valid/ready output toward the adder tree / output buffer.
- Ready/valid on both sides, full throughput: one product per cycle, no bubble between windows.

---
 rtl/psum_acc_pkg.sv | 25 ++
 rtl/psum_accumulator_if.sv | 45 ++++
 rtl/psum_sat_add.sv | 35 +++
 rtl/psum_accumulator.sv | 122 ++++++++++++
 tb/tb_psum_accumulator.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/psum_acc_pkg.sv
// psum_accumulator shared types and constants.
// Optional feature macro: PSUM_ACC_SATURATE_EN (saturating accumulate).
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Product width seen by the accumulator and the multiplier.
    function automatic int p_width(input int i_w, input int f_w);
        return i_w + f_w;
    endfunction

    // Widest supported saturating accumulator.
    localparam int SAT_W_MAX = 64;

    // Signed limits at SAT_W_MAX; narrowed by arithmetic shift.
    localparam logic signed [SAT_W_MAX-1:0] SAT_MAX_64 =
        {1'b0, {(SAT_W_MAX-1){1'b1}}};
    localparam logic signed [SAT_W_MAX-1:0] SAT_MIN_64 =
        {1'b1, {(SAT_W_MAX-1){1'b0}}};

endpackage

// File: rtl/psum_accumulator_if.sv
// Product input / sum output bundle of psum_accumulator.
// Optional feature macro: PSUM_ACC_SATURATE_EN (no effect here).
interface psum_accumulator_if
    import psum_acc_pkg::*;
#(
    parameter int I_WIDTH   = 8,
    parameter int F_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) ();

    localparam int P_WIDTH = p_width(I_WIDTH, F_WIDTH);

    logic [LEN_WIDTH-1:0] len_i;
    logic [P_WIDTH-1:0]   in_mul_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [ACC_WIDTH-1:0] out_sum_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 busy_o;

    modport master (
        output len_i,
        output in_mul_i,
        output in_valid_i,
        input  in_ready_o,
        input  out_sum_o,
        input  out_valid_o,
        output out_ready_i,
        input  busy_o
    );

    modport slave (
        input  len_i,
        input  in_mul_i,
        input  in_valid_i,
        output in_ready_o,
        output out_sum_o,
        output out_valid_o,
        input  out_ready_i,
        output busy_o
    );

endinterface

// File: rtl/psum_sat_add.sv
// Combinational signed adder for the partial-sum accumulator.
// Macro PSUM_ACC_SATURATE_EN: clamp to signed limits, else wrap.
module psum_sat_add
    import psum_acc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum
);

    logic signed [WIDTH-1:0] raw;

    assign raw = a + b;

`ifdef PSUM_ACC_SATURATE_EN
    localparam logic signed [WIDTH-1:0] MAX_V =
        WIDTH'(SAT_MAX_64 >>> (SAT_W_MAX - WIDTH));
    localparam logic signed [WIDTH-1:0] MIN_V =
        WIDTH'(SAT_MIN_64 >>> (SAT_W_MAX - WIDTH));

    logic ovf_pos;
    logic ovf_neg;

    // Same-sign operands with a flipped result sign overflowed.
    assign ovf_pos = ~a[WIDTH-1] & ~b[WIDTH-1] & raw[WIDTH-1];
    assign ovf_neg = a[WIDTH-1] & b[WIDTH-1] & ~raw[WIDTH-1];

    assign sum = ovf_pos ? MAX_V : (ovf_neg ? MIN_V : raw);
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates len_i signed products into one partial sum per window.
// Macro PSUM_ACC_SATURATE_EN: saturating instead of wrapping adds.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int I_WIDTH   = 8,
    parameter int F_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    psum_accumulator_if.slave bus
);

    localparam int P_WIDTH = p_width(I_WIDTH, F_WIDTH);

    if (ACC_WIDTH < P_WIDTH) begin : g_width_check
        $error("psum_accumulator: ACC_WIDTH < I_WIDTH+F_WIDTH");
    end

    state_t state;
    state_t state_d;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] add_res;
    logic signed [P_WIDTH-1:0]   mul;

    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] cnt_d;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_d;
    logic [LEN_WIDTH-1:0] len_eff;

    logic ready;
    logic accept;
    logic transfer;

    assign mul      = bus.in_mul_i;
    assign prod_ext = ACC_WIDTH'(mul);
    assign len_eff  = (bus.len_i == '0) ? LEN_WIDTH'(1) : bus.len_i;
    assign cnt_inc  = cnt + LEN_WIDTH'(1);

    // HOLD only takes a product when the finished sum leaves too.
    assign ready = (state == IDLE) || (state == ACCUM) ||
                   ((state == HOLD) && bus.out_ready_i);

    assign bus.in_ready_o  = ready & rst_n;
    assign bus.out_valid_o = (state == HOLD);
    assign bus.busy_o      = (state == ACCUM);
    assign bus.out_sum_o   = acc;

    assign accept   = bus.in_valid_i & bus.in_ready_o;
    assign transfer = bus.out_valid_o & bus.out_ready_i;

    psum_sat_add #(
        .WIDTH (ACC_WIDTH)
    ) u_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (add_res)
    );

    // Next state and next datapath values.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        len_d   = len_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    len_d   = len_eff;
                    acc_d   = prod_ext;
                    cnt_d   = LEN_WIDTH'(1);
                    state_d = (len_eff == LEN_WIDTH'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_res;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (transfer && accept) begin
                    len_d   = len_eff;
                    acc_d   = prod_ext;
                    cnt_d   = LEN_WIDTH'(1);
                    state_d = (len_eff == LEN_WIDTH'(1)) ? HOLD : ACCUM;
                end else if (transfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator.
// Overflow expectation follows PSUM_ACC_SATURATE_EN.
module tb_psum_accumulator;

    logic clk = 1'b0;
    logic rst_n;

    int n_chk  = 0;
    int n_pass = 0;
    int busy_cnt;
    int prods [4] = '{10, -3, 7, 100};

    // Free-running clock.
    always #5 clk = ~clk;

    psum_accumulator_if #(
        .I_WIDTH(8), .F_WIDTH(8), .ACC_WIDTH(32), .LEN_WIDTH(8)
    ) bus ();

    psum_accumulator_if #(
        .I_WIDTH(8), .F_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)
    ) bus16 ();

    psum_accumulator #(
        .I_WIDTH(8), .F_WIDTH(8), .ACC_WIDTH(32), .LEN_WIDTH(8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    psum_accumulator #(
        .I_WIDTH(8), .F_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)
    ) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input int m);
        bus.in_valid_i = v;
        bus.in_mul_i   = 16'(m);
    endtask

    function automatic longint sum32();
        return longint'($signed(bus.out_sum_o));
    endfunction

    // Directed stimulus and checks.
    initial begin
        rst_n           = 1'b0;
        bus.len_i       = '0;
        bus.in_mul_i    = '0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        bus16.len_i       = '0;
        bus16.in_mul_i    = '0;
        bus16.in_valid_i  = 1'b0;
        bus16.out_ready_i = 1'b1;

        tick();
        tick();
        check("rst_in_ready", longint'(bus.in_ready_o), 0);
        check("rst_out_valid", longint'(bus.out_valid_o), 0);
        check("rst_busy", longint'(bus.busy_o), 0);
        check("rst_sum", sum32(), 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", longint'(bus.in_ready_o), 1);

        // Basic window of four.
        bus.len_i = 8'd4;
        busy_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, prods[i]);
            tick();
            busy_cnt += int'(bus.busy_o);
            if (i == 2) begin
                check("t1_valid_early", longint'(bus.out_valid_o), 0);
            end
        end
        check("t1_valid", longint'(bus.out_valid_o), 1);
        check("t1_sum", sum32(), 114);
        put(1'b0, 0);
        tick();
        busy_cnt += int'(bus.busy_o);
        check("t1_valid_drop", longint'(bus.out_valid_o), 0);
        check("t1_busy_cycles", longint'(busy_cnt), 3);

        // Length 0 then length 1, back to back.
        bus.len_i = 8'd0;
        put(1'b1, -32768);
        tick();
        check("t2_len0_valid", longint'(bus.out_valid_o), 1);
        check("t2_len0_sum", sum32(), -32768);
        check("t2_len0_busy", longint'(bus.busy_o), 0);
        bus.len_i = 8'd1;
        tick();
        check("t2_len1_valid", longint'(bus.out_valid_o), 1);
        check("t2_len1_sum", sum32(), -32768);
        check("t2_len1_busy", longint'(bus.busy_o), 0);
        put(1'b0, 0);
        tick();
        check("t2_idle", longint'(bus.out_valid_o), 0);

        // Backpressure, then transfer and accept together.
        bus.len_i       = 8'd2;
        bus.out_ready_i = 1'b0;
        put(1'b1, 5);
        tick();
        put(1'b1, 6);
        tick();
        put(1'b1, 9);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", longint'(bus.out_valid_o), 1);
            check("t3_hold_sum", sum32(), 11);
            check("t3_hold_ready", longint'(bus.in_ready_o), 0);
            if (i < 4) begin
                tick();
            end
        end
        bus.out_ready_i = 1'b1;
        #1;
        check("t3_release_ready", longint'(bus.in_ready_o), 1);
        tick();
        check("t3_new_busy", longint'(bus.busy_o), 1);
        check("t3_new_valid", longint'(bus.out_valid_o), 0);
        put(1'b1, 1);
        tick();
        check("t3_new_sum", sum32(), 10);
        check("t3_new_valid2", longint'(bus.out_valid_o), 1);
        put(1'b0, 0);
        tick();

        // Gaps in in_valid and a mid-window length change.
        bus.len_i = 8'd3;
        put(1'b1, 1);
        tick();
        put(1'b0, 0);
        bus.len_i = 8'd7;
        tick();
        tick();
        check("t4_gap_busy", longint'(bus.busy_o), 1);
        put(1'b1, 2);
        tick();
        put(1'b0, 0);
        bus.len_i = 8'd3;
        tick();
        bus.len_i = 8'd7;
        tick();
        check("t4_gap_valid", longint'(bus.out_valid_o), 0);
        put(1'b1, 3);
        tick();
        check("t4_valid", longint'(bus.out_valid_o), 1);
        check("t4_sum", sum32(), 6);
        put(1'b0, 0);
        tick();

        // Overflow on the 16-bit accumulator.
        bus16.len_i      = 8'd2;
        bus16.in_valid_i = 1'b1;
        bus16.in_mul_i   = 16'd20000;
        tick();
        tick();
        bus16.in_valid_i = 1'b0;
        check("t5_valid", longint'(bus16.out_valid_o), 1);
`ifdef PSUM_ACC_SATURATE_EN
        check("t5_sum", longint'($signed(bus16.out_sum_o)), 32767);
`else
        check("t5_sum", longint'($signed(bus16.out_sum_o)), -25536);
`endif
        tick();

        // Reset in the middle of a window.
        bus.len_i = 8'd4;
        put(1'b1, 3);
        tick();
        put(1'b1, 4);
        tick();
        check("t6_busy_pre", longint'(bus.busy_o), 1);
        put(1'b0, 0);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", longint'(bus.out_valid_o), 0);
        check("t6_rst_busy", longint'(bus.busy_o), 0);
        check("t6_rst_ready", longint'(bus.in_ready_o), 0);
        rst_n     = 1'b1;
        bus.len_i = 8'd1;
        put(1'b1, 42);
        tick();
        check("t6_valid", longint'(bus.out_valid_o), 1);
        check("t6_sum", sum32(), 42);
        put(1'b0, 0);
        tick();
        check("t6_idle", longint'(bus.out_valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
